// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl
//   Scan controller for an eight-digit seven-segment display. A 32-bit hex
//   value plus per-digit enable and decimal-point masks are loaded into a
//   staging buffer. The buffer is committed to the display registers only at
//   a frame boundary, so a scan never shows a half-updated value.
//   All eight segment bytes are presented in parallel. The external driver
//   picks one of them using idx.
//
// Parameters
//   TICK_DIV  clocks per digit slot (>= 2)
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active high
//   value      nibble k is shown on digit k
//   dp_mask    bit k lights the decimal point of digit k
//   digit_en   bit k = 0 blanks digit k completely
//   lz_blank   1 = suppress leading zeros
//   load       strobe; samples value/dp_mask/digit_en/lz_blank into staging
//   pend       staging holds data not yet committed
//   idx        current digit 0..7 (bit 3 always 0)
//   frame      one-cycle pulse on the commit/wrap cycle
//   seg0..seg7 active-high segment bytes {A,B,C,D,E,F,G,DP}
module sseg_scan_ctrl #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  digit_en,
  input  logic        lz_blank,
  input  logic        load,
  output logic        pend,
  output logic [3:0]  idx,
  output logic        frame,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3,
  output logic [7:0]  seg4,
  output logic [7:0]  seg5,
  output logic [7:0]  seg6,
  output logic [7:0]  seg7
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx_q;
  logic          tick;

  logic [31:0] stg_value;
  logic [7:0]  stg_dp;
  logic [7:0]  stg_en;
  logic        stg_lz;

  logic [31:0] disp_value;
  logic [7:0]  disp_dp;
  logic [7:0]  disp_en;
  logic        disp_lz;

  logic [7:0]  seg_arr [8];
  logic [7:0]  seg_tmp;
  logic [3:0]  nib;
  logic [2:0]  k;
  logic        zero_run;

  assign tick  = (cnt == CNT_MAX);
  assign frame = tick && (idx_q == 3'd7);
  assign idx   = {1'b0, idx_q};

  function automatic logic [7:0] enc(input logic [3:0] n);
    logic [7:0] s;
    unique case (n)
      4'h0: s = 8'hFC;
      4'h1: s = 8'h60;
      4'h2: s = 8'hDA;
      4'h3: s = 8'hF2;
      4'h4: s = 8'h66;
      4'h5: s = 8'hB6;
      4'h6: s = 8'hBE;
      4'h7: s = 8'hE0;
      4'h8: s = 8'hFE;
      4'h9: s = 8'hF6;
      4'hA: s = 8'hEE;
      4'hB: s = 8'h3E;
      4'hC: s = 8'h9C;
      4'hD: s = 8'h7A;
      4'hE: s = 8'h9E;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx_q      <= '0;
      pend       <= 1'b0;
      stg_value  <= '0;
      stg_dp     <= '0;
      stg_en     <= '0;
      stg_lz     <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
      disp_en    <= '0;
      disp_lz    <= 1'b0;
    end else begin
      if (tick) begin
        cnt   <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end

      // Commit reads the pre-edge staging, so a load landing on the same
      // edge is kept for the following frame rather than being lost.
      if (frame && pend) begin
        disp_value <= stg_value;
        disp_dp    <= stg_dp;
        disp_en    <= stg_en;
        disp_lz    <= stg_lz;
      end

      if (load) begin
        stg_value <= value;
        stg_dp    <= dp_mask;
        stg_en    <= digit_en;
        stg_lz    <= lz_blank;
        pend      <= 1'b1;
      end else if (frame) begin
        pend <= 1'b0;
      end
    end
  end

  // Walk from digit 7 down so zero_run says "this digit and all above are 0".
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) seg_arr[i] = '0;
    zero_run = 1'b1;
    seg_tmp  = '0;
    nib      = '0;
    k        = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      k        = 3'(7 - i);
      nib      = disp_value[4*k +: 4];
      zero_run = zero_run & (nib == 4'h0);
      seg_tmp  = enc(nib);
      if (disp_lz && zero_run && (k != 3'd0)) seg_tmp[7:1] = '0;
      seg_tmp[0] = seg_tmp[0] | disp_dp[k];
      if (!disp_en[k]) seg_tmp = '0;
      seg_arr[k] = seg_tmp;
    end
  end

  assign seg0 = seg_arr[0];
  assign seg1 = seg_arr[1];
  assign seg2 = seg_arr[2];
  assign seg3 = seg_arr[3];
  assign seg4 = seg_arr[4];
  assign seg5 = seg_arr[5];
  assign seg6 = seg_arr[6];
  assign seg7 = seg_arr[7];

endmodule
